// File: rtl/immu_sram_ctrl_if.sv
// Host-side bus of the IMMU SRAM controller: flush, request handshake, response and init status.
interface immu_sram_ctrl_if #(
    parameter int AW = 6,
    parameter int DW = 22
) ();
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_busy;

    modport master (
        output flush, req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_busy
    );

    modport slave (
        input  flush, req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_busy
    );
endinterface

// File: rtl/immu_sram_ctrl.sv
// Sequences single-word host accesses to a strobed SRAM and clears the whole array
// after reset or on flush. Every SRAM pin is driven straight from a flop.
module immu_sram_ctrl #(
    parameter int AW    = 6,
    parameter int DW    = 22,
    parameter int DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    immu_sram_ctrl_if.slave     bus,
    output logic [AW-1:0]       sram_a,
    output logic [DW-1:0]       sram_i,
    output logic                sram_ce,
    output logic                sram_web,
    output logic                sram_oeb,
    output logic                sram_csb,
    input  logic [DW-1:0]       sram_o
);
    typedef enum logic [2:0] {
        S_INIT_SETUP,
        S_INIT_STROBE,
        S_INIT_HOLD,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_FINISH
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;
    logic          flush_pend_q, flush_pend_d;
    logic          we_q, we_d;
    logic          init_busy_q, init_busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [AW-1:0] sram_a_q, sram_a_d;
    logic [DW-1:0] sram_i_q, sram_i_d;
    logic          sram_ce_q, sram_ce_d;
    logic          sram_web_q, sram_web_d;
    logic          sram_oeb_q, sram_oeb_d;
    logic          sram_csb_q, sram_csb_d;
    logic          start_init;

    always_comb begin
        state_d      = state_q;
        init_addr_d  = init_addr_q;
        flush_pend_d = flush_pend_q;
        we_d         = we_q;
        init_busy_d  = init_busy_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        sram_a_d     = sram_a_q;
        sram_i_d     = sram_i_q;
        sram_ce_d    = sram_ce_q;
        sram_web_d   = sram_web_q;
        sram_oeb_d   = sram_oeb_q;
        sram_csb_d   = sram_csb_q;
        start_init   = 1'b0;

        case (state_q)
            S_INIT_SETUP: begin
                state_d   = S_INIT_STROBE;
                sram_ce_d = 1'b1;
            end
            S_INIT_STROBE: begin
                state_d   = S_INIT_HOLD;
                sram_ce_d = 1'b0;
            end
            S_INIT_HOLD: begin
                if (init_addr_q == LAST_ADDR) begin
                    state_d     = S_IDLE;
                    init_addr_d = '0;
                    init_busy_d = 1'b0;
                    sram_csb_d  = 1'b1;
                    sram_web_d  = 1'b1;
                end else begin
                    state_d     = S_INIT_SETUP;
                    init_addr_d = init_addr_q + AW'(1);
                    sram_a_d    = init_addr_q + AW'(1);
                end
            end
            S_IDLE: begin
                // Flush has priority over a simultaneous request.
                if (bus.flush) begin
                    start_init = 1'b1;
                end else if (bus.req_valid) begin
                    state_d    = S_SETUP;
                    we_d       = bus.req_we;
                    sram_a_d   = bus.req_addr;
                    sram_i_d   = bus.req_wdata;
                    sram_web_d = ~bus.req_we;
                    sram_csb_d = 1'b0;
                end
            end
            S_SETUP: begin
                state_d   = S_STROBE;
                sram_ce_d = 1'b1;
                if (bus.flush) flush_pend_d = 1'b1;
            end
            S_STROBE: begin
                state_d    = S_FINISH;
                sram_ce_d  = 1'b0;
                sram_oeb_d = we_q;
                if (bus.flush) flush_pend_d = 1'b1;
            end
            S_FINISH: begin
                rsp_valid_d = 1'b1;
                if (!we_q) rsp_rdata_d = sram_o;
                sram_oeb_d = 1'b1;
                if (bus.flush || flush_pend_q) begin
                    start_init = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    sram_csb_d = 1'b1;
                    sram_web_d = 1'b1;
                end
            end
            default: start_init = 1'b1;
        endcase

        if (start_init) begin
            state_d      = S_INIT_SETUP;
            init_addr_d  = '0;
            init_busy_d  = 1'b1;
            flush_pend_d = 1'b0;
            sram_a_d     = '0;
            sram_i_d     = '0;
            sram_csb_d   = 1'b0;
            sram_web_d   = 1'b0;
            sram_oeb_d   = 1'b1;
            sram_ce_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT_SETUP;
            init_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            we_q         <= 1'b0;
            init_busy_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            sram_a_q     <= '0;
            sram_i_q     <= '0;
            sram_ce_q    <= 1'b0;
            sram_web_q   <= 1'b0;
            sram_oeb_q   <= 1'b1;
            sram_csb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            flush_pend_q <= flush_pend_d;
            we_q         <= we_d;
            init_busy_q  <= init_busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            sram_a_q     <= sram_a_d;
            sram_i_q     <= sram_i_d;
            sram_ce_q    <= sram_ce_d;
            sram_web_q   <= sram_web_d;
            sram_oeb_q   <= sram_oeb_d;
            sram_csb_q   <= sram_csb_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !flush_pend_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.init_busy = init_busy_q;
    assign sram_a        = sram_a_q;
    assign sram_i        = sram_i_q;
    assign sram_ce       = sram_ce_q;
    assign sram_web      = sram_web_q;
    assign sram_oeb      = sram_oeb_q;
    assign sram_csb      = sram_csb_q;
endmodule

// File: tb/tb_immu_sram_ctrl.sv
// Directed bench for immu_sram_ctrl with a behavioural strobed SRAM attached to its pins.
module tb_immu_sram_ctrl;
    localparam int AW = 6;
    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_i;
    logic          sram_ce, sram_web, sram_oeb, sram_csb;
    logic [DW-1:0] sram_o;

    int checks = 0;
    int errors = 0;

    immu_sram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    immu_sram_ctrl #(.AW(AW), .DW(DW), .DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sram_a   (sram_a),
        .sram_i   (sram_i),
        .sram_ce  (sram_ce),
        .sram_web (sram_web),
        .sram_oeb (sram_oeb),
        .sram_csb (sram_csb),
        .sram_o   (sram_o)
    );

    always #5 clk = ~clk;

    // SRAM model: preloaded with non-zero junk so the clear is observable.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] rd_lat;
    int init_pulses = 0;
    int init_bad    = 0;
    int exp_a       = 0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 22'h3ABCD ^ 22'(i);
        rd_lat = '0;
    end

    always @(posedge sram_ce) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           rd_lat <= mem[sram_a];
        end
        if (bus.init_busy) begin
            if (sram_a != AW'(exp_a) || sram_web || sram_csb || sram_i != '0) init_bad++;
            exp_a = (exp_a == 63) ? 0 : exp_a + 1;
            init_pulses++;
        end
    end

    assign sram_o = sram_oeb ? '1 : rd_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input int flush_at, output int n, output int rsps);
        n = 0;
        rsps = 0;
        while (bus.init_busy && n < 400) begin
            bus.flush = (n == flush_at);
            tick();
            n++;
            if (bus.rsp_valid) rsps++;
            if (bus.init_busy && bus.req_ready) rsps += 100;
        end
        bus.flush = 1'b0;
    endtask

    task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             output logic [DW-1:0] rd, output int lat, output int oeb_lows,
                             output int oeb_k);
        int w = 0;
        while (!bus.req_ready && w < 500) begin
            tick();
            w++;
        end
        chk("ready_before_access", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        oeb_lows = 0;
        oeb_k = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (!sram_oeb) begin
                oeb_lows++;
                oeb_k = lat;
            end
            tick();
            lat++;
        end
        rd = bus.rsp_rdata;
        $display("access we=%0d addr=0x%0h wdata=0x%0h rdata=0x%0h latency=%0d", we, addr, wd, rd, lat);
    endtask

    logic [DW-1:0] rd;
    int lat, ol, ok, n, rsps, base;
    int acc_cyc [4];
    logic [DW-1:0] b2b_rd [4];
    int nacc, nrsp;
    logic acc;

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_init_busy", 32'(bus.init_busy), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_sram_pins", {26'(sram_a), sram_csb, sram_web, sram_oeb, sram_ce, 2'b00}, 32'b0010_00);

        base = init_pulses;
        wait_init(-1, n, rsps);
        chk("init_edges", 32'(n), 192);
        chk("init_pulses", 32'(init_pulses - base), 64);
        chk("init_no_rsp", 32'(rsps), 0);
        chk("idle_ready", 32'(bus.req_ready), 1);
        chk("idle_pins", {28'd0, sram_csb, sram_web, sram_oeb, sram_ce}, 32'b1110);
        $display("init done after %0d edges", n);

        do_access(1'b0, 6'd9, '0, rd, lat, ol, ok);
        chk("rd9_cleared", 32'(rd), 0);
        chk("rd9_lat", 32'(lat), 4);

        do_access(1'b1, 6'd5, 22'h2A5A5, rd, lat, ol, ok);
        chk("wr5_lat", 32'(lat), 4);
        chk("wr5_oeb_lows", 32'(ol), 0);
        chk("wr5_rdata_kept", 32'(rd), 0);
        tick();
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 0);

        do_access(1'b0, 6'd5, '0, rd, lat, ol, ok);
        chk("rd5_data", 32'(rd), 32'h2A5A5);
        chk("rd5_lat", 32'(lat), 4);
        chk("rd5_oeb_lows", 32'(ol), 1);
        chk("rd5_oeb_finish", 32'(ok), 3);
        chk("rd5_oeb_after", 32'(sram_oeb), 1);

        do_access(1'b1, 6'h3F, 22'h155AA, rd, lat, ol, ok);
        chk("wr3f_lat", 32'(lat), 4);

        // Back-to-back reads with req_valid held high.
        tick();
        bus.req_we = 1'b0;
        bus.req_addr = 6'h3F;
        bus.req_valid = 1'b1;
        nacc = 0;
        nrsp = 0;
        for (int c = 0; c < 16; c++) begin
            acc = bus.req_valid && bus.req_ready;
            tick();
            if (bus.rsp_valid) begin
                if (nrsp < 4) b2b_rd[nrsp] = bus.rsp_rdata;
                nrsp++;
            end
            if (acc) begin
                if (nacc < 4) acc_cyc[nacc] = c;
                nacc++;
                if (nacc == 1) bus.req_addr = 6'h00;
                else           bus.req_valid = 1'b0;
            end
        end
        $display("back-to-back accepts=%0d responses=%0d", nacc, nrsp);
        chk("b2b_accepts", 32'(nacc), 2);
        chk("b2b_rsps", 32'(nrsp), 2);
        chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 4);
        chk("b2b_rd_3f", 32'(b2b_rd[0]), 32'h155AA);
        chk("b2b_rd_00", 32'(b2b_rd[1]), 0);

        // Flush raised in the STROBE cycle of a write to address 7.
        bus.req_we = 1'b1;
        bus.req_addr = 6'd7;
        bus.req_wdata = 22'h1;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_wr_pending_rsp", 32'(bus.rsp_valid), 0);
        tick();
        chk("flush_wr_rsp", 32'(bus.rsp_valid), 1);
        chk("flush_wr_init_busy", 32'(bus.init_busy), 1);
        chk("flush_wr_ready", 32'(bus.req_ready), 0);
        base = init_pulses;
        wait_init(-1, n, rsps);
        $display("flush during write: init %0d edges", n);
        chk("flush_wr_init_edges", 32'(n), 192);
        chk("flush_wr_pulses", 32'(init_pulses - base), 64);
        do_access(1'b0, 6'd7, '0, rd, lat, ol, ok);
        chk("flush_rd7", 32'(rd), 0);

        // Flush and request together in IDLE; a second flush mid-init must be ignored.
        tick();
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 6'd3;
        tick();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_idle_busy", 32'(bus.init_busy), 1);
        chk("flush_idle_ready", 32'(bus.req_ready), 0);
        chk("flush_idle_csb", 32'(sram_csb), 0);
        base = init_pulses;
        wait_init(60, n, rsps);
        $display("flush in idle: init %0d edges", n);
        chk("flush_idle_edges", 32'(n - 1), 191);
        chk("flush_idle_no_rsp", 32'(rsps), 0);
        chk("flush_idle_pulses", 32'(init_pulses - base), 64);

        // Reset asserted during FINISH of a read.
        do_access(1'b1, 6'd2, 22'h3FFFF, rd, lat, ol, ok);
        tick();
        bus.req_we = 1'b0;
        bus.req_addr = 6'd2;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_oeb_finish", 32'(sram_oeb), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_mid_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_mid_busy", 32'(bus.init_busy), 1);
        chk("rst_mid_a", 32'(sram_a), 0);
        base = init_pulses;
        wait_init(-1, n, rsps);
        $display("reset during read: init %0d edges", n);
        chk("rst_mid_edges", 32'(n), 192);
        chk("rst_mid_no_rsp", 32'(rsps), 0);
        chk("rst_mid_pulses", 32'(init_pulses - base), 64);
        do_access(1'b0, 6'd2, '0, rd, lat, ol, ok);
        chk("rst_mid_rd2", 32'(rd), 0);

        chk("init_sequence_bad", 32'(init_bad), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end
endmodule
